// File: rtl/compare_sequencer_pkg.sv
// Shared types and select codes for the comparator sweep sequencer.
// The package is named cmp_seq_pkg so that the comparator and the sequencer share one namespace.
package cmp_seq_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} cs_state_t;

    localparam logic [1:0] SEL_GT  = 2'd0;
    localparam logic [1:0] SEL_LT  = 2'd1;
    localparam logic [1:0] SEL_EQ  = 2'd2;
    localparam logic [1:0] SEL_NEQ = 2'd3;

    localparam int CMP_DW = 8;
    localparam int CMP_YW = 16;

endpackage

// File: rtl/comparator_module.sv
// Combinational 8-bit unsigned comparator with a 16-bit result word.
// Y[1]/Y[0] carry A>B / A<B for codes 0..2; both carry A!=B for NEQ.
module comparator_module
    import cmp_seq_pkg::*;
(
    input  logic [CMP_DW-1:0] A,
    input  logic [CMP_DW-1:0] B,
    input  logic [1:0]        select,
    output logic [CMP_YW-1:0] Y
);

    always_comb begin
        Y = '0;
        if (select == SEL_NEQ) begin
            Y[1] = (A != B);
            Y[0] = (A != B);
        end else begin
            Y[1] = (A > B);
            Y[0] = (A < B);
        end
    end

endmodule

// File: rtl/compare_sequencer.sv
// Sweeps one comparator through GT/LT/EQ/NEQ for a captured operand pair and
// returns the decoded 4-bit flag vector plus a consistency error bit.
module compare_sequencer
    import cmp_seq_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_flags,
    output logic             out_err,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    cs_state_t        state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [DW-1:0]    a_q, a_d, b_q, b_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic             yhi_q, yhi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      cmp_y;
    logic             dec_bit;

    comparator_module u_cmp (
        .A      (a_q),
        .B      (b_q),
        .select (sel_q),
        .Y      (cmp_y)
    );

    // Exactly one of gt/lt/eq, neq the inverse of eq, and no stray upper Y bits.
    function automatic logic check_err(input logic [3:0] f, input logic yhi);
        logic [1:0] onehot_sum;
        onehot_sum = {1'b0, f[0]} + {1'b0, f[1]} + {1'b0, f[2]};
        return (onehot_sum != 2'd1) || (f[3] != ~f[2]) || yhi;
    endfunction

    always_comb begin
        case (sel_q)
            SEL_GT:  dec_bit = cmp_y[1];
            SEL_LT:  dec_bit = cmp_y[0];
            SEL_EQ:  dec_bit = ~(cmp_y[1] | cmp_y[0]);
            default: dec_bit = cmp_y[0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        a_d       = a_q;
        b_d       = b_q;
        flags_d   = flags_q;
        err_d     = err_q;
        yhi_d     = yhi_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    flags_d = '0;
                    err_d   = 1'b0;
                    yhi_d   = 1'b0;
                    sel_d   = SEL_GT;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                flags_d[sel_q] = dec_bit;
                yhi_d          = yhi_q | (|cmp_y[15:2]);
                sel_d          = sel_q + 2'd1;
                if (sel_q == SEL_NEQ) begin
                    err_d   = check_err(flags_d, yhi_d);
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
            yhi_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
            err_q   <= err_d;
            yhi_q   <= yhi_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_flags = flags_q;
    assign out_err   = err_q;
    assign busy      = (state_q != IDLE);
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Self-checking bench for compare_sequencer: directed scenarios plus a randomized
// back-to-back run against a behavioural flag model.
module tb_compare_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_flags;
    logic        out_err;
    logic        busy;
    logic [15:0] txn_count;

    int checks = 0;
    int errors = 0;

    compare_sequencer #(.DW(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flags (out_flags),
        .out_err   (out_err),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    // Reference: {neq, eq, lt, gt} straight from unsigned arithmetic.
    function automatic logic [3:0] model_flags(input logic [7:0] a, input logic [7:0] b);
        return {a != b, a == b, a < b, a > b};
    endfunction

    // Offers a pair from posedge+1 until accepted; leaves the bench at posedge+1 after acceptance.
    task automatic accept_pair(input logic [7:0] a, input logic [7:0] b, input bit keep,
                               output bit ok, output int waited);
        in_a = a; in_b = b; in_valid = 1'b1; ok = 1'b0; waited = 0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1; waited++;
        end
        if (ok) begin
            @(posedge clk); #1;
        end
        if (!keep || !ok) in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_flags !== 4'b0)   begin errors++; $display("FAIL reset_flags got %b want 0000", out_flags); end
        checks++; if (out_err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", out_err); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (txn_count !== 16'd0)  begin errors++; $display("FAIL reset_count got %0d want 0", txn_count); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0]  va [3] = '{8'h50, 8'h07, 8'h3C};
        logic [7:0]  vb [3] = '{8'h20, 8'hC3, 8'h3C};
        logic [3:0]  vf [3] = '{4'b1001, 4'b1010, 4'b0100};
        bit ok; int w; int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            accept_pair(va[i], vb[i], 1'b0, ok, w);
            checks++; if (!ok) begin errors++; $display("FAIL basic_accept[%0d] got no accept want accept", i); end
            wait_valid(lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 4", i, lat); end
            checks++; if (out_flags !== vf[i]) begin errors++; $display("FAIL basic_flags[%0d] got %b want %b", i, out_flags, vf[i]); end
            checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err[%0d] got %b want 0", i, out_err); end
            @(posedge clk); #1;
            checks++; if (txn_count !== 16'(i + 1)) begin errors++; $display("FAIL basic_count[%0d] got %0d want %0d", i, txn_count, i + 1); end
        end
    endtask

    task automatic test_backpressure();
        bit ok; int w; int lat; int bad;
        logic [15:0] c0;
        c0 = txn_count;
        out_ready = 1'b0;
        accept_pair(8'hFF, 8'h00, 1'b0, ok, w);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept got no accept want accept"); end
        wait_valid(lat);
        in_a = 8'h00; in_b = 8'h05; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_flags !== 4'b1001 || in_ready !== 1'b0 || out_err !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        checks++; if (out_flags !== 4'b1001) begin errors++; $display("FAIL bp_flags got %b want 1001", out_flags); end
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got %b want 1", in_ready); end
        checks++; if (txn_count !== c0 + 16'd1) begin errors++; $display("FAIL bp_count got %0d want %0d", txn_count, c0 + 16'd1); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored busy=%b out_valid=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_reset_midsweep();
        bit ok; int w; int lat;
        out_ready = 1'b1;
        accept_pair(8'h10, 8'h20, 1'b0, ok, w);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
        checks++; if (out_flags !== 4'b0)  begin errors++; $display("FAIL rst_mid_flags got %b want 0000", out_flags); end
        checks++; if (txn_count !== 16'd0) begin errors++; $display("FAIL rst_mid_count got %0d want 0", txn_count); end
        @(posedge clk); #1;
        rst = 1'b0;
        accept_pair(8'h01, 8'h02, 1'b0, ok, w);
        wait_valid(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rst_mid_latency got %0d want 4", lat); end
        checks++; if (out_flags !== 4'b1010 || out_err !== 1'b0) begin errors++; $display("FAIL rst_mid_after got flags=%b err=%b want 1010 0", out_flags, out_err); end
        @(posedge clk); #1;
        checks++; if (txn_count !== 16'd1) begin errors++; $display("FAIL rst_mid_count_after got %0d want 1", txn_count); end
    endtask

    task automatic test_back_to_back();
        bit ok; int w; int lat;
        logic [7:0] a, b;
        logic [3:0] exp;
        logic [15:0] c0;
        int unstable;
        c0 = txn_count;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 8'($urandom);
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = 8'hFF;
                2: b = 8'h00;
                default: b = 8'($urandom);
            endcase
            exp = model_flags(a, b);
            accept_pair(a, b, 1'b1, ok, w);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_accept[%0d] got no accept want accept", i); end
            if (i > 0) begin
                checks++; if (w != 0) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d wait cycles want 0", i, w); end
            end
            wait_valid(lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want 4", i, lat); end
            checks++; if (out_flags !== exp) begin errors++; $display("FAIL b2b_flags[%0d] a=%h b=%h got %b want %b", i, a, b, out_flags, exp); end
            checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d] got %b want 0", i, out_err); end
            unstable = 0;
            out_ready = ($urandom_range(0, 2) != 0);
            for (int s = 0; s < 20 && !out_ready; s++) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || out_flags !== exp) unstable++;
                out_ready = ($urandom_range(0, 2) != 0);
            end
            out_ready = 1'b1;
            checks++; if (unstable != 0) begin errors++; $display("FAIL b2b_hold[%0d] got %0d unstable cycles want 0", i, unstable); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (txn_count !== c0 + 16'd256) begin errors++; $display("FAIL b2b_count got %0d want %0d", txn_count, c0 + 16'd256); end
    endtask

    task automatic test_force_err();
        bit ok; int w; int lat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        force dut.cmp_y = 16'h0003;
        accept_pair(8'h20, 8'h50, 1'b0, ok, w);
        wait_valid(lat);
        checks++; if (out_flags !== 4'b1011) begin errors++; $display("FAIL force11_flags got %b want 1011", out_flags); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL force11_err got %b want 1", out_err); end
        @(posedge clk); #1;
        force dut.cmp_y = 16'h0100;
        accept_pair(8'h05, 8'h05, 1'b0, ok, w);
        wait_valid(lat);
        checks++; if (out_flags !== 4'b0100) begin errors++; $display("FAIL forcehi_flags got %b want 0100", out_flags); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL forcehi_err got %b want 1", out_err); end
        @(posedge clk); #1;
        release dut.cmp_y;
        accept_pair(8'h33, 8'h22, 1'b0, ok, w);
        wait_valid(lat);
        checks++; if (out_flags !== 4'b1001 || out_err !== 1'b0) begin errors++; $display("FAIL force_recover got flags=%b err=%b want 1001 0", out_flags, out_err); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_midsweep();
        test_back_to_back();
        test_force_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
